// File: rtl/control_sequencer.sv
// Microprogram next-state sequencer: picks the next 7-bit microstate from ns_sel/cr_addr each clock.
// Latency one cycle, all outputs registered; wait-MOC holds the state until moc or a TIMEOUT abort.
module control_sequencer #(
  parameter logic [6:0] RESET_ADDR = 7'd0,
  parameter logic [6:0] FETCH_ADDR = 7'd1,
  parameter logic [6:0] UNDEF_ADDR = 7'd4,
  parameter logic [6:0] ABORT_ADDR = 7'd2,
  parameter int         TIMEOUT    = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] enc_state,
  input  logic       cond,
  input  logic       moc,
  input  logic [2:0] ns_sel,
  input  logic [6:0] cr_addr,
  output logic [6:0] state,
  output logic       abort,
  output logic [7:0] wait_cnt
);

  typedef enum logic [2:0] {
    NS_DECODE = 3'd0,
    NS_INC    = 3'd1,
    NS_JUMP   = 3'd2,
    NS_CJUMP  = 3'd3,
    NS_WAIT   = 3'd4,
    NS_CALL   = 3'd5,
    NS_RET    = 3'd6,
    NS_RSVD   = 3'd7
  } ns_sel_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  ns_sel_t    sel;
  logic [6:0] state_inc;
  logic [6:0] ret_addr;
  logic [6:0] state_nxt;
  logic [6:0] ret_nxt;
  logic [7:0] wait_nxt;
  logic       abort_nxt;

  assign sel       = ns_sel_t'(ns_sel);
  assign state_inc = state + 7'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RESET_ADDR;
      wait_cnt <= 8'd0;
      abort    <= 1'b0;
      ret_addr <= FETCH_ADDR;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      abort    <= abort_nxt;
      ret_addr <= ret_nxt;
    end
  end

  // wait_cnt only survives a cycle that stays in wait-MOC; every other path clears it.
  always_comb begin
    state_nxt = FETCH_ADDR;
    wait_nxt  = 8'd0;
    abort_nxt = 1'b0;
    ret_nxt   = ret_addr;
    case (sel)
      NS_DECODE: begin
        if (!cond)                 state_nxt = FETCH_ADDR;
        else if (enc_state == 7'd0) state_nxt = UNDEF_ADDR;
        else                       state_nxt = enc_state;
      end
      NS_INC:   state_nxt = state_inc;
      NS_JUMP:  state_nxt = cr_addr;
      NS_CJUMP: state_nxt = cond ? cr_addr : state_inc;
      NS_WAIT: begin
        if (moc) begin
          state_nxt = state_inc;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = ABORT_ADDR;
          abort_nxt = 1'b1;
        end else begin
          state_nxt = state;
          wait_nxt  = wait_cnt + 8'd1;
        end
      end
      NS_CALL: begin
        state_nxt = cr_addr;
        ret_nxt   = state_inc;
      end
      NS_RET:  state_nxt = ret_addr;
      NS_RSVD: state_nxt = FETCH_ADDR;
      default: state_nxt = FETCH_ADDR;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: plays the microstore, queues expected outputs per edge.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] enc_state;
  logic       cond;
  logic       moc;
  logic [2:0] ns_sel;
  logic [6:0] cr_addr;
  logic [6:0] state;
  logic       abort;
  logic [7:0] wait_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0] ns;
    logic [6:0] cr;
    logic       c;
    logic       m;
    logic [6:0] enc;
    logic [6:0] es;
    logic [7:0] ew;
    logic       ea;
  } step_t;

  typedef struct packed {
    logic [6:0] es;
    logic [7:0] ew;
    logic       ea;
  } exp_t;

  exp_t sb[$];

  control_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .enc_state (enc_state),
    .cond      (cond),
    .moc       (moc),
    .ns_sel    (ns_sel),
    .cr_addr   (cr_addr),
    .state     (state),
    .abort     (abort),
    .wait_cnt  (wait_cnt)
  );

  always #5 clk = ~clk;

  function automatic step_t mk(input logic [2:0] ns, input logic [6:0] cr, input logic c,
                               input logic m, input logic [6:0] enc, input logic [6:0] es,
                               input logic [7:0] ew, input logic ea);
    mk = '{ns, cr, c, m, enc, es, ew, ea};
  endfunction

  // Drive one microinstruction, queue what the next edge must produce, then sample after it.
  task automatic apply(input step_t s);
    ns_sel    = s.ns;
    cr_addr   = s.cr;
    cond      = s.c;
    moc       = s.m;
    enc_state = s.enc;
    sb.push_back('{s.es, s.ew, s.ea});
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock edge.
  task automatic test_async_reset(input string name);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({state, wait_cnt, abort} !== {7'd0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL %s async reset: state=%0d wait_cnt=%0d abort=%0b, expected state=0 wait_cnt=0 abort=0",
               name, state, wait_cnt, abort);
    end
    #2 reset = 1'b0;
  endtask

  task automatic test_reset();
    step_t sq[$];
    exp_t  e;
    reset = 1'b1; ns_sel = 3'd1; cr_addr = 7'd0; cond = 1'b0; moc = 1'b0; enc_state = 7'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({state, wait_cnt, abort} !== {7'd0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold: state=%0d wait_cnt=%0d abort=%0b, expected 0/0/0", state, wait_cnt, abort);
    end
    #3 reset = 1'b0;
    #1;
    sq.push_back(mk(3'd1, 7'd0, 1'b0, 1'b0, 7'd0, 7'd1, 8'd0, 1'b0));
    sq.push_back(mk(3'd1, 7'd0, 1'b0, 1'b0, 7'd0, 7'd2, 8'd0, 1'b0));
    sq.push_back(mk(3'd2, 7'd37, 1'b0, 1'b0, 7'd0, 7'd37, 8'd0, 1'b0));
    foreach (sq[i]) begin
      apply(sq[i]);
      e = sb.pop_front();
      checks++;
      if ({state, wait_cnt, abort} !== {e.es, e.ew, e.ea}) begin
        errors++;
        $display("FAIL reset step %0d: state=%0d wait_cnt=%0d abort=%0b, expected %0d/%0d/%0b",
                 i, state, wait_cnt, abort, e.es, e.ew, e.ea);
      end
    end
    test_async_reset("reset_at_37");
    apply(mk(3'd1, 7'd0, 1'b0, 1'b0, 7'd0, 7'd1, 8'd0, 1'b0));
    e = sb.pop_front();
    checks++;
    if (state !== e.es) begin
      errors++;
      $display("FAIL reset_release: state=%0d, expected %0d", state, e.es);
    end
  endtask

  task automatic test_decode();
    step_t sq[$];
    exp_t  e;
    sq.push_back(mk(3'd0, 7'd0, 1'b1, 1'b0, 7'd7,   7'd7,   8'd0, 1'b0));
    sq.push_back(mk(3'd0, 7'd0, 1'b0, 1'b0, 7'd7,   7'd1,   8'd0, 1'b0));
    sq.push_back(mk(3'd0, 7'd0, 1'b1, 1'b0, 7'd0,   7'd4,   8'd0, 1'b0));
    sq.push_back(mk(3'd0, 7'd0, 1'b1, 1'b0, 7'd100, 7'd100, 8'd0, 1'b0));
    foreach (sq[i]) begin
      apply(sq[i]);
      e = sb.pop_front();
      checks++;
      if ({state, wait_cnt, abort} !== {e.es, e.ew, e.ea}) begin
        errors++;
        $display("FAIL decode step %0d: state=%0d wait_cnt=%0d abort=%0b, expected %0d/%0d/%0b",
                 i, state, wait_cnt, abort, e.es, e.ew, e.ea);
      end
    end
  endtask

  task automatic test_wait_moc();
    step_t sq[$];
    exp_t  e;
    // moc on the 4th cycle of the wait state
    sq.push_back(mk(3'd2, 7'd3, 1'b0, 1'b0, 7'd0, 7'd3, 8'd0, 1'b0));
    for (int k = 1; k <= 3; k++)
      sq.push_back(mk(3'd4, 7'd0, 1'b0, 1'b0, 7'd0, 7'd3, 8'(k), 1'b0));
    sq.push_back(mk(3'd4, 7'd0, 1'b0, 1'b1, 7'd0, 7'd4, 8'd0, 1'b0));
    // full timeout, abort lasts one cycle
    sq.push_back(mk(3'd2, 7'd3, 1'b0, 1'b0, 7'd0, 7'd3, 8'd0, 1'b0));
    for (int k = 1; k <= 14; k++)
      sq.push_back(mk(3'd4, 7'd0, 1'b0, 1'b0, 7'd0, 7'd3, 8'(k), 1'b0));
    sq.push_back(mk(3'd4, 7'd0, 1'b0, 1'b0, 7'd0, 7'd2, 8'd0, 1'b1));
    sq.push_back(mk(3'd2, 7'd10, 1'b0, 1'b0, 7'd0, 7'd10, 8'd0, 1'b0));
    // moc exactly at the timeout edge wins
    sq.push_back(mk(3'd2, 7'd3, 1'b0, 1'b0, 7'd0, 7'd3, 8'd0, 1'b0));
    for (int k = 1; k <= 14; k++)
      sq.push_back(mk(3'd4, 7'd0, 1'b0, 1'b0, 7'd0, 7'd3, 8'(k), 1'b0));
    sq.push_back(mk(3'd4, 7'd0, 1'b0, 1'b1, 7'd0, 7'd4, 8'd0, 1'b0));
    // leaving a wait by another select clears the counter
    sq.push_back(mk(3'd2, 7'd3, 1'b0, 1'b0, 7'd0, 7'd3, 8'd0, 1'b0));
    for (int k = 1; k <= 5; k++)
      sq.push_back(mk(3'd4, 7'd0, 1'b0, 1'b0, 7'd0, 7'd3, 8'(k), 1'b0));
    sq.push_back(mk(3'd2, 7'd50, 1'b0, 1'b0, 7'd0, 7'd50, 8'd0, 1'b0));
    foreach (sq[i]) begin
      apply(sq[i]);
      e = sb.pop_front();
      checks++;
      if ({state, wait_cnt, abort} !== {e.es, e.ew, e.ea}) begin
        errors++;
        $display("FAIL wait_moc step %0d: state=%0d wait_cnt=%0d abort=%0b, expected %0d/%0d/%0b",
                 i, state, wait_cnt, abort, e.es, e.ew, e.ea);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    step_t sq[$];
    exp_t  e;
    sq.push_back(mk(3'd2, 7'd3, 1'b0, 1'b0, 7'd0, 7'd3, 8'd0, 1'b0));
    for (int k = 1; k <= 6; k++)
      sq.push_back(mk(3'd4, 7'd0, 1'b0, 1'b0, 7'd0, 7'd3, 8'(k), 1'b0));
    foreach (sq[i]) begin
      apply(sq[i]);
      e = sb.pop_front();
      checks++;
      if ({state, wait_cnt, abort} !== {e.es, e.ew, e.ea}) begin
        errors++;
        $display("FAIL mid_wait step %0d: state=%0d wait_cnt=%0d abort=%0b, expected %0d/%0d/%0b",
                 i, state, wait_cnt, abort, e.es, e.ew, e.ea);
      end
    end
    test_async_reset("reset_mid_wait");
    // reach a timeout again and reset while abort is high
    apply(mk(3'd2, 7'd3, 1'b0, 1'b0, 7'd0, 7'd3, 8'd0, 1'b0));
    void'(sb.pop_front());
    repeat (15) begin
      apply(mk(3'd4, 7'd0, 1'b0, 1'b0, 7'd0, 7'd0, 8'd0, 1'b0));
      void'(sb.pop_front());
    end
    checks++;
    if ({state, abort} !== {7'd2, 1'b1}) begin
      errors++;
      $display("FAIL abort_before_reset: state=%0d abort=%0b, expected 2/1", state, abort);
    end
    test_async_reset("reset_during_abort");
  endtask

  task automatic test_call_return();
    step_t sq[$];
    exp_t  e;
    sq.push_back(mk(3'd2, 7'd20,  1'b0, 1'b0, 7'd0, 7'd20,  8'd0, 1'b0));
    sq.push_back(mk(3'd5, 7'd100, 1'b0, 1'b0, 7'd0, 7'd100, 8'd0, 1'b0));
    sq.push_back(mk(3'd1, 7'd0,   1'b0, 1'b0, 7'd0, 7'd101, 8'd0, 1'b0));
    sq.push_back(mk(3'd6, 7'd0,   1'b0, 1'b0, 7'd0, 7'd21,  8'd0, 1'b0));
    sq.push_back(mk(3'd2, 7'd40,  1'b0, 1'b0, 7'd0, 7'd40,  8'd0, 1'b0));
    sq.push_back(mk(3'd5, 7'd60,  1'b0, 1'b0, 7'd0, 7'd60,  8'd0, 1'b0));
    sq.push_back(mk(3'd5, 7'd90,  1'b0, 1'b0, 7'd0, 7'd90,  8'd0, 1'b0));
    sq.push_back(mk(3'd6, 7'd0,   1'b0, 1'b0, 7'd0, 7'd61,  8'd0, 1'b0));
    sq.push_back(mk(3'd2, 7'd127, 1'b0, 1'b0, 7'd0, 7'd127, 8'd0, 1'b0));
    sq.push_back(mk(3'd5, 7'd5,   1'b0, 1'b0, 7'd0, 7'd5,   8'd0, 1'b0));
    sq.push_back(mk(3'd6, 7'd0,   1'b0, 1'b0, 7'd0, 7'd0,   8'd0, 1'b0));
    foreach (sq[i]) begin
      apply(sq[i]);
      e = sb.pop_front();
      checks++;
      if ({state, wait_cnt, abort} !== {e.es, e.ew, e.ea}) begin
        errors++;
        $display("FAIL call_return step %0d: state=%0d wait_cnt=%0d abort=%0b, expected %0d/%0d/%0b",
                 i, state, wait_cnt, abort, e.es, e.ew, e.ea);
      end
    end
    // a call leaves ret_addr=0 above; reset must restore FETCH_ADDR
    apply(mk(3'd5, 7'd9, 1'b0, 1'b0, 7'd0, 7'd9, 8'd0, 1'b0));
    void'(sb.pop_front());
    test_async_reset("reset_before_return");
    apply(mk(3'd6, 7'd0, 1'b0, 1'b0, 7'd0, 7'd1, 8'd0, 1'b0));
    e = sb.pop_front();
    checks++;
    if (state !== e.es) begin
      errors++;
      $display("FAIL return_after_reset: state=%0d, expected %0d", state, e.es);
    end
  endtask

  task automatic test_wrap_jumps();
    step_t sq[$];
    exp_t  e;
    sq.push_back(mk(3'd2, 7'd127, 1'b0, 1'b0, 7'd0, 7'd127, 8'd0, 1'b0));
    sq.push_back(mk(3'd1, 7'd0,   1'b0, 1'b0, 7'd0, 7'd0,   8'd0, 1'b0));
    sq.push_back(mk(3'd3, 7'd30,  1'b1, 1'b0, 7'd0, 7'd30,  8'd0, 1'b0));
    sq.push_back(mk(3'd3, 7'd30,  1'b0, 1'b0, 7'd0, 7'd31,  8'd0, 1'b0));
    sq.push_back(mk(3'd2, 7'd127, 1'b0, 1'b0, 7'd0, 7'd127, 8'd0, 1'b0));
    sq.push_back(mk(3'd3, 7'd30,  1'b0, 1'b0, 7'd0, 7'd0,   8'd0, 1'b0));
    sq.push_back(mk(3'd7, 7'd90,  1'b1, 1'b1, 7'd9, 7'd1,   8'd0, 1'b0));
    sq.push_back(mk(3'd2, 7'd31,  1'b0, 1'b0, 7'd0, 7'd31,  8'd0, 1'b0));
    sq.push_back(mk(3'd7, 7'd0,   1'b0, 1'b0, 7'd0, 7'd1,   8'd0, 1'b0));
    foreach (sq[i]) begin
      apply(sq[i]);
      e = sb.pop_front();
      checks++;
      if ({state, wait_cnt, abort} !== {e.es, e.ew, e.ea}) begin
        errors++;
        $display("FAIL wrap_jumps step %0d: state=%0d wait_cnt=%0d abort=%0b, expected %0d/%0d/%0b",
                 i, state, wait_cnt, abort, e.es, e.ew, e.ea);
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_wait_moc();
    test_reset_mid_wait();
    test_call_return();
    test_wrap_jumps();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Microprogram next-state sequencer for the processor control unit. It holds the current 7-bit microstate and chooses the next one each clock from the control word in the current microinstruction. The choices are increment, jump, decode, wait for memory, call and return. Decode consumes the 7-bit state number produced by the instruction encoder. The microstore ROM is addressed combinationally by `state` and returns `ns_sel` and `cr_addr` within the same cycle.

## Interface

Parameters:
- RESET_ADDR, 0: microstate loaded on reset.
- FETCH_ADDR, 1: first fetch microstate; target when the decode condition fails and for `ns_sel` = 7.
- UNDEF_ADDR, 4: target when decoding an encoder value of 0.
- ABORT_ADDR, 2: target on MOC timeout.
- TIMEOUT, 15: maximum number of cycles spent in a wait-MOC state before abort (1..255).

Ports:
- clk, input, 1: system clock; all state updates on rising edge.
- reset, input, 1: asynchronous, active-high reset.
- enc_state, input, 7: microstate number from the instruction encoder.
- cond, input, 1: condition-code test result for the current instruction (1 = pass).
- moc, input, 1: memory operation complete.
- ns_sel, input, 3: next-state select field of the current microinstruction.
- cr_addr, input, 7: control-register address field of the current microinstruction.
- state, output, 7: current microstate, which addresses the microstore.
- abort, output, 1: one-cycle pulse marking a MOC timeout.
- wait_cnt, output, 8: cycles elapsed in the current wait-MOC state.

## Operation

Next-state selection, by `ns_sel`:
- 0, decode: if `cond` = 0, go to FETCH_ADDR. Otherwise, if `enc_state` = 0, go to UNDEF_ADDR. Otherwise go to `enc_state`.
- 1, increment: go to `state` + 1, modulo 128 (127 wraps to 0).
- 2, jump: go to `cr_addr`.
- 3, conditional jump: go to `cr_addr` if `cond` = 1, else to `state` + 1.
- 4, wait-MOC:
  - if `moc` = 1, go to `state` + 1 and clear `wait_cnt`;
  - otherwise, if `wait_cnt` = TIMEOUT − 1, go to ABORT_ADDR, pulse `abort` and clear `wait_cnt`;
  - otherwise hold `state` and increment `wait_cnt`.
- 5, call: go to `cr_addr` and save `state` + 1 (mod 128) into the single-entry return register `ret_addr`.
- 6, return: go to `ret_addr`. A return without a prior call goes to FETCH_ADDR, because `ret_addr` resets to FETCH_ADDR.
- 7, reserved: go to FETCH_ADDR.

Wait counter and abort:
- `wait_cnt` is cleared whenever the next cycle's `ns_sel` is not 4. It never exceeds TIMEOUT − 1.
- `abort` is registered. It is high for exactly the one cycle in which `state` = ABORT_ADDR after a timeout, and 0 in all other cycles.

Other rules:
- `moc` takes priority over timeout when both occur in the same cycle.
- A second call before a return overwrites `ret_addr`; there is no nesting.
- Reset values: `state` = RESET_ADDR, `wait_cnt` = 0, `abort` = 0, `ret_addr` = FETCH_ADDR.
- Reset asserted mid-sequence, including mid-wait, forces all registers to their reset values immediately, with no clock required.
- All inputs are sampled only at rising clock edges. No combinational path runs from any input to any output.

## Timing

- Next-state latency is one cycle: inputs valid before edge N determine `state` after edge N.
- The `ns_sel` and `cr_addr` that apply at edge N are the ROM outputs for the `state` that holds during cycle N.
- Decode uses `enc_state` and `cond` as sampled at the decode edge. The encoder output must therefore be stable, with the IR loaded, at least one cycle earlier.
- A wait-MOC state with `moc` arriving after k cycles (k < TIMEOUT) occupies k+1 cycles. `wait_cnt` reads 0..k during that stay.
- Timeout case: ABORT_ADDR is entered TIMEOUT cycles after the wait state was first entered.
- Reset release: the first edge after deassertion evaluates the microinstruction at RESET_ADDR.

## Test plan

- Reset: assert `reset` asynchronously between edges with `state` = 37 → `state` = 0, `wait_cnt` = 0 and `abort` = 0 without a clock edge. After release with `ns_sel` = 1, `state` goes 0→1→2.
- Decode: `ns_sel` = 0, `cond` = 1, `enc_state` = 7 → `state` = 7. With `cond` = 0 → `state` = 1. With `cond` = 1 and `enc_state` = 0 → `state` = 4.
- Wait-MOC: `state` = 3, `ns_sel` = 4, `moc` rises on the 4th cycle → `state` stays 3 for 3 edges with `wait_cnt` 0,1,2,3, then `state` = 4 and `wait_cnt` = 0. With `moc` held 0 → after 15 edges `state` = 2, `abort` high for 1 cycle. With `moc` = 1 exactly at the timeout edge → `state` = 4 and no abort.
- Call/return: at `state` = 20, `ns_sel` = 5, `cr_addr` = 100 → `state` = 100. Later `ns_sel` = 6 → `state` = 21. A return issued right after reset → `state` = 1.
- Wrap and conditional jump: `state` = 127 with `ns_sel` = 1 → `state` = 0. `ns_sel` = 3, `cr_addr` = 30: `cond` = 1 → `state` = 30; `cond` = 0 → `state` + 1.
- Reserved/jump: `ns_sel` = 7 → `state` = 1. `ns_sel` = 2, `cr_addr` = 31 → `state` = 31.
